// File: rtl/selection_indicator.sv
// Parking-spot selection indicator: latches a city/spot request, blinks it until
// confirmed, then holds it solid, or flashes an error pattern for invalid or occupied spots.
module selection_indicator #(
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned ERR_TOGGLES = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [1:0] city,
    input  logic [3:0] spot,
    input  logic       confirm,
    input  logic [8:0] occupied,
    output logic [8:0] led_spot,
    output logic [2:0] led_city,
    output logic [6:0] hex_spot,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1)   ? $clog2(BLINK_DIV)   : 1;
    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned TOG_W   = (ERR_TOGGLES > 1) ? $clog2(ERR_TOGGLES) : 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PENDING   = 2'd1;
    localparam logic [1:0] CONFIRMED = 2'd2;
    localparam logic [1:0] ERROR     = 2'd3;

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [1:0]         cur_city;
    logic [3:0]         cur_spot;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [TOG_W-1:0]   tog_cnt;
    logic               blink_wrap;
    logic               sel_valid;
    logic               restart_blink;
    logic               enter_confirm;
    logic               enter_error;

    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign sel_valid  = (spot <= 4'd8) && (city != 2'b11);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; load wins over confirm and always restarts the blink
    always_comb begin
        next_state    = state;
        restart_blink = 1'b0;
        enter_confirm = 1'b0;
        enter_error   = 1'b0;
        if (load) begin
            next_state    = sel_valid ? PENDING : ERROR;
            restart_blink = 1'b1;
            enter_error   = !sel_valid;
        end else begin
            case (state)
                PENDING: begin
                    if (confirm) begin
                        if (occupied[cur_spot]) begin
                            next_state    = ERROR;
                            restart_blink = 1'b1;
                            enter_error   = 1'b1;
                        end else begin
                            next_state    = CONFIRMED;
                            enter_confirm = 1'b1;
                        end
                    end
                end
                CONFIRMED: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) next_state = IDLE;
                end
                ERROR: begin
                    if (blink_wrap && (tog_cnt == TOG_W'(ERR_TOGGLES - 1))) next_state = IDLE;
                end
                default: ;
            endcase
        end
    end

    // Selection latch, pulses and timing counters
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_city  <= 2'd0;
            cur_spot  <= 4'd0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            hold_cnt  <= '0;
            tog_cnt   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= enter_confirm;
            err  <= enter_error;
            if (load) begin
                cur_city <= city;
                cur_spot <= spot;
            end
            if (restart_blink) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_wrap) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            hold_cnt <= (state == CONFIRMED) ? hold_cnt + HOLD_W'(1) : '0;
            if (restart_blink || (state != ERROR)) begin
                tog_cnt <= '0;
            end else if (blink_wrap) begin
                tog_cnt <= tog_cnt + TOG_W'(1);
            end
        end
    end

    function automatic logic [6:0] digit(input logic [3:0] d);
        case (d)
            4'd0:    digit = 7'b1000000;
            4'd1:    digit = 7'b1111001;
            4'd2:    digit = 7'b0100100;
            4'd3:    digit = 7'b0110000;
            4'd4:    digit = 7'b0011001;
            4'd5:    digit = 7'b0010010;
            4'd6:    digit = 7'b0000010;
            4'd7:    digit = 7'b1111000;
            4'd8:    digit = 7'b0000000;
            default: digit = 7'b1111111;
        endcase
    endfunction

    logic [8:0] spot_mask;
    logic [2:0] city_onehot;

    // Display decode from registered state over live occupancy
    always_comb begin
        spot_mask = 9'(1) << cur_spot;
        case (cur_city)
            2'd0:    city_onehot = 3'b100;
            2'd1:    city_onehot = 3'b010;
            2'd2:    city_onehot = 3'b001;
            default: city_onehot = 3'b000;
        endcase
        led_spot = occupied;
        led_city = 3'b000;
        hex_spot = 7'b1111111;
        busy     = (state != IDLE);
        case (state)
            PENDING: begin
                led_spot = (occupied & ~spot_mask) | ({9{phase}} & spot_mask);
                led_city = city_onehot;
                hex_spot = digit(cur_spot);
            end
            CONFIRMED: begin
                led_spot = occupied | spot_mask;
                led_city = city_onehot;
                hex_spot = digit(cur_spot);
            end
            ERROR: begin
                led_spot = {9{phase}};
                hex_spot = 7'b0000110;
            end
            default: ;
        endcase
    end

endmodule
